seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the combinational add/sub/mul/div/mod ALU.
- Operands and opcode are accepted with a start/busy/done handshake.
- ADD, SUB and XOR complete in one cycle. MUL uses iterative shift-add; DIV and MOD use iterative restoring division.
- Sits between the operand register file and the result bus. Results and error flags are registered and held until the next completion.

---
 rtl/seq_alu_pkg.sv | 21 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_divider.sv | 46 ++++
 rtl/seq_alu.sv | 149 ++++++++++++++
 tb/tb_seq_alu.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and err bit positions.
// Opcodes are plain ints so each user can size them to its own OPW.
package seq_alu_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;
    localparam int OP_MOD = 4;
    localparam int OP_XOR = 5;

    localparam int ERR_OVF  = 0;
    localparam int ERR_DIV0 = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the operand register file (master) and seq_alu (slave).
// Handshake: start is sampled only while busy=0; an accepted start raises busy on the same edge,
// busy drops and done pulses for one cycle when result/err update, and a start in that done
// cycle is accepted (busy is already 0). A start seen while busy=1 is dropped, never queued.
interface seq_alu_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic                 start;
    logic [OPW-1:0]       op;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [1:0]           err;

    modport master (
        output start, op, in_a, in_b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, in_a, in_b,
        output busy, done, result, err
    );
endinterface

// File: rtl/seq_alu_divider.sv
// Restoring shift-subtract divider datapath: one quotient bit per step, WIDTH steps per divide.
// After WIDTH steps quotient holds A/B and remainder holds A%B (unsigned, truncating).
module seq_alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] trial;

    // The trial difference only needs WIDTH bits: when it is kept it is below the divisor.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, div_q});
        trial   = shifted[WIDTH-1:0] - div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? trial : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/XOR, WIDTH-step shift-add MUL and restoring DIV/MOD.
// Result and err are registered and held until the next done pulse.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic   clk,
    input  logic   rst,
    seq_alu_if.slave bus,
    output state_t fsm_state
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [OPW-1:0]     op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;
    logic [1:0]         err_q;

    logic               iter_req;
    logic               is_sub;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum_full;
    logic               carry_msb;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               div_step;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] res_n;
    logic [1:0]         err_n;

    // Only MUL and a real divide need the iteration phase; divide-by-zero finishes immediately.
    always_comb begin
        iter_req = (bus.op == OPW'(OP_MUL)) ||
                   (((bus.op == OPW'(OP_DIV)) || (bus.op == OPW'(OP_MOD))) && (bus.in_b != '0));
    end

    // Product register holds {partial sum, remaining multiplier bits}; shifts right each step.
    always_comb begin
        upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a_q : {WIDTH{1'b0}})};
        mul_next  = {upper_sum, prod[WIDTH-1:1]};
        div_step  = (state == S_ITER) && ((op_q == OPW'(OP_DIV)) || (op_q == OPW'(OP_MOD)));
    end

    seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == S_IDLE) && bus.start),
        .step      (div_step),
        .dividend  (bus.in_a),
        .divisor   (bus.in_b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // SUB is A + ~B + 1 so ADD and SUB share one adder and one overflow rule.
    always_comb begin
        is_sub    = (op_q == OPW'(OP_SUB));
        addend    = is_sub ? ~b_q : b_q;
        sum_full  = {1'b0, a_q} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
        carry_msb = a_q[WIDTH-1] ^ addend[WIDTH-1] ^ sum_full[WIDTH-1];
    end

    always_comb begin
        res_n = '0;
        err_n = '0;
        case (op_q)
            OPW'(OP_ADD), OPW'(OP_SUB): begin
                res_n          = {{WIDTH{sum_full[WIDTH]}}, sum_full[WIDTH-1:0]};
                err_n[ERR_OVF] = carry_msb ^ sum_full[WIDTH];
            end
            OPW'(OP_MUL): res_n = prod;
            OPW'(OP_DIV): begin
                if (b_q == '0) err_n[ERR_DIV0] = 1'b1;
                else           res_n = {{WIDTH{1'b0}}, quotient};
            end
            OPW'(OP_MOD): begin
                if (b_q == '0) err_n[ERR_DIV0] = 1'b1;
                else           res_n = {{WIDTH{1'b0}}, remainder};
            end
            OPW'(OP_XOR): res_n = {{WIDTH{1'b0}}, a_q ^ b_q};
            default: begin
                res_n = '0;
                err_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod     <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        prod   <= {{WIDTH{1'b0}}, bus.in_b};
                        busy_q <= 1'b1;
                        if (iter_req) begin
                            state <= S_ITER;
                            cnt   <= CW'(WIDTH);
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_ITER: begin
                    if (op_q == OPW'(OP_MUL)) prod <= mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIN;
                end
                S_FIN: begin
                    result_q <= res_n;
                    err_q    <= err_n;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign fsm_state  = state;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): hand-computed vectors for every opcode, latency,
// busy length, error flags, ignored/back-to-back starts and reset abort.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic   clk;
    logic   rst;
    state_t fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    seq_alu_if #(.WIDTH(16), .OPW(4)) bus ();

    seq_alu #(.WIDTH(16), .OPW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: present a request at negedge; it is accepted at the following posedge.
    task automatic launch(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.in_a  = a;
        bus.in_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp_res,
                          input logic [1:0] exp_err, input int exp_lat);
        int lat;
        int bcnt;
        exp_q.push_back(exp_res);
        launch(o, a, b);
        wait_done(lat, bcnt);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_q.pop_front());
        check({tag, "_err"}, {30'd0, bus.err}, {30'd0, exp_err});
    endtask

    initial begin
        int lat;
        int bcnt;
        int lat2;
        logic saw_done;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_res", bus.result, 32'd0);
        check("rst_err", {30'd0, bus.err}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // Small operands
        run_op("add_s", 4'd0, 16'd15, 16'd126, 32'h0000_008D, 2'b00, 1);
        run_op("sub_s", 4'd1, 16'd15, 16'd126, 32'h0000_FF91, 2'b00, 1);
        run_op("mul_s", 4'd2, 16'd15, 16'd126, 32'd1890, 2'b00, 17);
        run_op("div_s", 4'd3, 16'd15, 16'd126, 32'd0, 2'b00, 17);
        run_op("mod_s", 4'd4, 16'd15, 16'd126, 32'd15, 2'b00, 17);

        // Large operands
        run_op("add_l", 4'd0, 16'hF3FF, 16'h647E, 32'hFFFF_587D, 2'b00, 1);
        run_op("mul_l", 4'd2, 16'hF3FF, 16'h647E, 32'd1606923138, 2'b00, 17);
        run_op("div_l", 4'd3, 16'hF3FF, 16'h647E, 32'd2, 2'b00, 17);
        run_op("mod_l", 4'd4, 16'hF3FF, 16'h647E, 32'd11011, 2'b00, 17);
        run_op("xor", 4'd5, 16'd15, 16'd126, 32'h0000_0071, 2'b00, 1);
        run_op("rsvd", 4'd9, 16'hF3FF, 16'h647E, 32'd0, 2'b00, 1);

        // Divide by zero and signed overflow
        run_op("div0", 4'd3, 16'h1234, 16'd0, 32'd0, 2'b10, 1);
        run_op("mod0", 4'd4, 16'h1234, 16'd0, 32'd0, 2'b10, 1);
        run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 32'h0000_8000, 2'b01, 1);
        run_op("sub_ovf", 4'd1, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 2'b01, 1);

        // done lasts one cycle; result/err hold afterwards
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, bus.done}, 32'd0);
        check("hold_res", bus.result, 32'hFFFF_7FFF);
        check("hold_err", {30'd0, bus.err}, 32'd1);

        // start during a MUL is ignored
        launch(4'd2, 16'd15, 16'd126);
        repeat (3) @(posedge clk);
        #1;
        launch(4'd0, 16'd1, 16'd1);
        check("ign_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat2, bcnt);
        check("ign_lat", 32'(4 + lat2), 32'd17);
        check("ign_res", bus.result, 32'd1890);

        // back-to-back: new start issued in the done cycle
        check("b2b_done", {31'd0, bus.done}, 32'd1);
        run_op("b2b_add", 4'd0, 16'd1, 16'd1, 32'd2, 2'b00, 1);
        run_op("b2b_mul", 4'd2, 16'd300, 16'd300, 32'd90000, 2'b00, 17);

        // reset after 8 divide steps aborts the operation
        launch(4'd3, 16'hF3FF, 16'h647E);
        repeat (8) @(posedge clk);
        #1;
        check("abort_state", {30'd0, fsm_state}, {30'd0, S_ITER});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_res", bus.result, 32'd0);
        check("abort_state2", {30'd0, fsm_state}, {30'd0, S_IDLE});
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_nodone", {31'd0, saw_done}, 32'd0);
        run_op("post_add", 4'd0, 16'h1234, 16'h1111, 32'h0000_2345, 2'b00, 1);

        lat = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
